// File: rtl/up_down_counter_if.sv
// up_down_counter_if
// Control/status bundle for up_down_counter. The instruction side
// (clear, count instruction) is driven by the master. The counter value
// and the limit pulse are driven back by the slave (the counter).
interface up_down_counter_if #(
    parameter int WIDTH = 20
);
    logic                    clear_i;
    logic [1:0]              count_instr_i;
    logic signed [WIDTH-1:0] counter_val_o;
    logic                    limit_o;

    modport master (
        output clear_i,
        output count_instr_i,
        input  counter_val_o,
        input  limit_o
    );

    modport slave (
        input  clear_i,
        input  count_instr_i,
        output counter_val_o,
        output limit_o
    );
endinterface

// File: rtl/up_down_counter.sv
// up_down_counter
// Signed up/down counter for the ADPLL loop path. It accumulates the
// phase-detector up/down decisions into a signed control word.
// Instruction encoding: 00 hold, 01 +STEP, 10 -STEP, 11 hold (reserved).
// At the signed range limits the result wraps by default. Defining
// UPDOWN_COUNTER_SATURATE_EN clamps the result at the limits instead.
// limit_o is a one-cycle registered pulse on every wrap or clamp.
module up_down_counter #(
    parameter int WIDTH = 20,
    parameter int STEP  = 1
) (
    input  logic               fpga_clk_i,
    input  logic               reset_n_i,
    up_down_counter_if.slave   bus
);

    // Elaboration-time guard on the parameter ranges. The arithmetic below
    // relies on STEP <= 2^(WIDTH-2): with that bound the WIDTH+1 bit sum can
    // never overflow, so its top bit always gives the true sign.
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("up_down_counter: WIDTH must be in 2..32");
        end
        if (STEP < 1 || longint'(STEP) > (longint'(1) << (WIDTH - 2))) begin : g_bad_step
            $error("up_down_counter: STEP must be in 1..2^(WIDTH-2)");
        end
    endgenerate

    localparam logic signed [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

    localparam logic [1:0] INSTR_INC = 2'b01;
    localparam logic [1:0] INSTR_DEC = 2'b10;

`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};
`endif

    logic signed [WIDTH-1:0] value_reg;
    logic                    limit_reg;

    logic signed [WIDTH-1:0] value_next;
    logic                    limit_next;

    logic signed [WIDTH:0]   cur_ext;
    logic signed [WIDTH:0]   sum_ext;
    logic                    do_count;
    logic                    out_of_range;

    // Extend the current value by one bit, then add or subtract STEP.
    // out_of_range is set when the WIDTH+1 bit result does not fit
    // back into WIDTH bits.
    always_comb begin
        cur_ext      = {value_reg[WIDTH-1], value_reg};
        sum_ext      = cur_ext;
        do_count     = 1'b0;
        if (bus.count_instr_i == INSTR_INC) begin
            sum_ext  = cur_ext + STEP_EXT;
            do_count = 1'b1;
        end else if (bus.count_instr_i == INSTR_DEC) begin
            sum_ext  = cur_ext - STEP_EXT;
            do_count = 1'b1;
        end
        out_of_range = do_count && (sum_ext[WIDTH] != sum_ext[WIDTH-1]);
    end

    // Apply the boundary rule. The hold instructions keep the value and
    // drop the limit pulse.
    always_comb begin
        value_next = value_reg;
        limit_next = 1'b0;
        if (do_count) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
            if (out_of_range) begin
                // The sign of the extended sum shows which end was crossed.
                value_next = sum_ext[WIDTH] ? MIN_VAL : MAX_VAL;
            end else begin
                value_next = sum_ext[WIDTH-1:0];
            end
`else
            // Plain truncation gives two's-complement wrap-around.
            value_next = sum_ext[WIDTH-1:0];
`endif
            limit_next = out_of_range;
        end
    end

    // State update. Priority is reset, then clear, then the instruction.
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            value_reg <= '0;
            limit_reg <= 1'b0;
        end else if (bus.clear_i) begin
            value_reg <= '0;
            limit_reg <= 1'b0;
        end else begin
            value_reg <= value_next;
            limit_reg <= limit_next;
        end
    end

    assign bus.counter_val_o = value_reg;
    assign bus.limit_o       = limit_reg;

endmodule

// File: tb/tb_up_down_counter.sv
// tb_up_down_counter
// Four counters run in lockstep from shared clear/instruction stimulus:
// (WIDTH,STEP) = (20,1), (8,1), (20,4), (20,2^18). Each cycle the
// expected outputs of all four are pushed to a scoreboard queue. They are
// popped and compared one time unit after the clock edge. Directed checks
// cover the reset, increment, hold, clear, boundary and STEP=4 scenarios.
// Build with +define+UPDOWN_COUNTER_SATURATE_EN to check the clamping variant.
module tb_up_down_counter;

    localparam int N  = 4;
    localparam int W0 = 20, S0 = 1;
    localparam int W1 = 8,  S1 = 1;
    localparam int W2 = 20, S2 = 4;
    localparam int W3 = 20, S3 = 262144;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clear  = 1'b0;
    logic [1:0] instr  = 2'b00;

    always #5 clk = ~clk;

    up_down_counter_if #(.WIDTH(W0)) if0 ();
    up_down_counter_if #(.WIDTH(W1)) if1 ();
    up_down_counter_if #(.WIDTH(W2)) if2 ();
    up_down_counter_if #(.WIDTH(W3)) if3 ();

    assign if0.clear_i = clear;  assign if0.count_instr_i = instr;
    assign if1.clear_i = clear;  assign if1.count_instr_i = instr;
    assign if2.clear_i = clear;  assign if2.count_instr_i = instr;
    assign if3.clear_i = clear;  assign if3.count_instr_i = instr;

    up_down_counter #(.WIDTH(W0), .STEP(S0)) u0 (.fpga_clk_i(clk), .reset_n_i(rst_n), .bus(if0.slave));
    up_down_counter #(.WIDTH(W1), .STEP(S1)) u1 (.fpga_clk_i(clk), .reset_n_i(rst_n), .bus(if1.slave));
    up_down_counter #(.WIDTH(W2), .STEP(S2)) u2 (.fpga_clk_i(clk), .reset_n_i(rst_n), .bus(if2.slave));
    up_down_counter #(.WIDTH(W3), .STEP(S3)) u3 (.fpga_clk_i(clk), .reset_n_i(rst_n), .bus(if3.slave));

    logic signed [31:0] obs_v [N];
    logic               obs_l [N];
    assign obs_v[0] = 32'(signed'(if0.counter_val_o));
    assign obs_v[1] = 32'(signed'(if1.counter_val_o));
    assign obs_v[2] = 32'(signed'(if2.counter_val_o));
    assign obs_v[3] = 32'(signed'(if3.counter_val_o));
    assign obs_l[0] = if0.limit_o;
    assign obs_l[1] = if1.limit_o;
    assign obs_l[2] = if2.limit_o;
    assign obs_l[3] = if3.limit_o;

    int     wid [N] = '{W0, W1, W2, W3};
    int     stp [N] = '{S0, S1, S2, S3};
    longint mv  [N] = '{0, 0, 0, 0};
    bit     ml  [N] = '{0, 0, 0, 0};

    typedef struct packed {
        logic [N-1:0]       lim;
        logic [N-1:0][31:0] val;
    } exp_t;
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour: exact integer arithmetic, then the boundary rule.
    function automatic void model_step(input int i, input bit clr, input bit [1:0] ins);
        longint maxv = (longint'(1) << (wid[i] - 1)) - 1;
        longint minv = -(maxv + 1);
        longint span = longint'(1) << wid[i];
        longint n;
        if (clr) begin
            mv[i] = 0; ml[i] = 0;
            return;
        end
        if (ins == 2'b01)      n = mv[i] + stp[i];
        else if (ins == 2'b10) n = mv[i] - stp[i];
        else begin
            ml[i] = 0;
            return;
        end
`ifdef UPDOWN_COUNTER_SATURATE_EN
        if (n > maxv)      begin mv[i] = maxv; ml[i] = 1; end
        else if (n < minv) begin mv[i] = minv; ml[i] = 1; end
        else               begin mv[i] = n;    ml[i] = 0; end
`else
        if (n > maxv)      begin mv[i] = n - span; ml[i] = 1; end
        else if (n < minv) begin mv[i] = n + span; ml[i] = 1; end
        else               begin mv[i] = n;        ml[i] = 0; end
`endif
    endfunction

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic step(input bit clr, input bit [1:0] ins);
        exp_t e;
        clear = clr;
        instr = ins;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                mv[i] = 0; ml[i] = 0;
            end else begin
                model_step(i, clr, ins);
            end
            e.val[i] = mv[i][31:0];
            e.lim[i] = ml[i];
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sbq.pop_front();
            for (int i = 0; i < N; i++) begin
                check_val($sformatf("val%0d", i), obs_v[i], longint'(signed'(e.val[i])));
                check_val($sformatf("lim%0d", i), longint'(obs_l[i]), longint'(e.lim[i]));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with increment requested: all outputs stay 0.
        rst_n = 1'b0;
        repeat (4) step(1'b0, 2'b01);
        check_val("reset_val", obs_v[0], 0);
        check_val("reset_lim", longint'(obs_l[0]), 0);
        rst_n = 1'b1;

        // Count up 400, then down 500.
        repeat (400) step(1'b0, 2'b01);
        check_val("inc400", obs_v[0], 400);
        repeat (500) step(1'b0, 2'b10);
        check_val("dec500", obs_v[0], -100);

        // Hold with both hold encodings.
        repeat (5) step(1'b0, 2'b00);
        repeat (5) step(1'b0, 2'b11);
        check_val("hold", obs_v[0], -100);

        // Clear wins over increment.
        step(1'b1, 2'b01);
        check_val("clear0", obs_v[0], 0);
        check_val("clear2", obs_v[2], 0);

        // Boundary on the 8-bit counter.
        repeat (127) step(1'b0, 2'b01);
        check_val("at_max", obs_v[1], 127);
`ifdef UPDOWN_COUNTER_SATURATE_EN
        repeat (3) begin
            step(1'b0, 2'b01);
            check_val("sat_max_val", obs_v[1], 127);
            check_val("sat_max_lim", longint'(obs_l[1]), 1);
        end
        step(1'b1, 2'b00);
        repeat (128) step(1'b0, 2'b10);
        check_val("at_min", obs_v[1], -128);
        step(1'b0, 2'b10);
        check_val("sat_min_val", obs_v[1], -128);
        check_val("sat_min_lim", longint'(obs_l[1]), 1);
`else
        step(1'b0, 2'b01);
        check_val("wrap_up_val", obs_v[1], -128);
        check_val("wrap_up_lim", longint'(obs_l[1]), 1);
        step(1'b0, 2'b10);
        check_val("wrap_dn_val", obs_v[1], 127);
        check_val("wrap_dn_lim", longint'(obs_l[1]), 1);
`endif
        step(1'b0, 2'b00);
        check_val("lim_drop", longint'(obs_l[1]), 0);

        // Asynchronous reset in the middle of a cycle.
        repeat (3) step(1'b0, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            mv[i] = 0; ml[i] = 0;
            check_val($sformatf("async_val%0d", i), obs_v[i], 0);
            check_val($sformatf("async_lim%0d", i), longint'(obs_l[i]), 0);
        end
        repeat (2) step(1'b0, 2'b01);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 2'b01);
        check_val("resume", obs_v[0], 3);

        // STEP=4 sequence from a cleared state.
        step(1'b1, 2'b00);
        repeat (5) step(1'b0, 2'b01);
        check_val("step4_up", obs_v[2], 20);
        repeat (6) step(1'b0, 2'b10);
        check_val("step4_dn", obs_v[2], -4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_down_counter.md
Name: up_down_counter

Overview:
- Signed synchronous up/down counter; increments, decrements or holds each `fpga_clk_i` cycle according to a 2-bit instruction.
- Sits in the ADPLL loop path: it accumulates phase-detector up/down decisions into a signed control word for the loop filter / DCO.
- Provides a synchronous clear and boundary handling (wrap-around or saturation) at the signed range limits.

Parameters:
- WIDTH, 20, counter width in bits; two's-complement range -2^(WIDTH-1) .. 2^(WIDTH-1)-1; legal range 2..32.
- STEP, 1, unsigned magnitude added or subtracted per counting cycle; legal range 1 .. 2^(WIDTH-2).

Ports:
- fpga_clk_i  input  1  system clock; all state updates on the rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous clear, active-high.
- count_instr_i  input  2  count instruction: 00 hold, 01 increment, 10 decrement, 11 hold (reserved).
- counter_val_o  output  WIDTH  signed counter value, registered.
- limit_o  output  1  one-cycle pulse on a boundary event (a wrap, or a clamp when saturation is compiled in).

Behaviour:
- Reset: while `reset_n_i`=0, `counter_val_o`=0 and `limit_o`=0, asynchronously. Release is sampled synchronously.
- Priority each rising edge: reset > `clear_i` > `count_instr_i`.
- `clear_i`=1: `counter_val_o`<=0 and `limit_o`<=0 on the next edge, regardless of `count_instr_i`.
- 01: next value = current + STEP. 10: next value = current - STEP. 00 or 11: value held, `limit_o`<=0.
- Latency: one cycle. An instruction sampled at edge N is visible on `counter_val_o` after edge N.
- Continuous 01 from 0 gives 1, 2, 3, ... one per cycle (with STEP=1).
- Arithmetic: computed at WIDTH+1 bits signed, then the boundary rule is applied.
- Boundary, default (wrap): the result is truncated to WIDTH bits two's complement.
  - max + STEP wraps to the negative end; min - STEP wraps to the positive end.
  - `limit_o`=1 for the cycle following the wrapping edge.
- `limit_o` is registered and deasserts on the next edge unless another boundary event occurs.
- No internal state other than the value register and the `limit_o` register.
- Reset asserted mid-count: the output goes to 0 immediately and counting resumes from 0 after release.

Optional Feature:
- Macro `UPDOWN_COUNTER_SATURATE_EN`.
- Defined:
  - Increments that would exceed 2^(WIDTH-1)-1 clamp to that value.
  - Decrements below -2^(WIDTH-1) clamp to that value.
  - `limit_o`=1 for every cycle in which a clamp is applied, including repeated pushes while already at the limit.
- Undefined: wrap-around behaviour as in Behaviour; the saturation logic is not synthesised.

Test Plan:
- Reset: `reset_n_i`=0 with `count_instr_i`=01 for 4 cycles -> `counter_val_o`=0 and `limit_o`=0 throughout; assert reset asynchronously mid-cycle -> output 0 before the next edge.
- Increment: release reset, `count_instr_i`=01 for 400 cycles (WIDTH=20, STEP=1) -> `counter_val_o`=400; then 10 for 500 cycles -> -100.
- Hold/clear: `count_instr_i`=00 or 11 for 10 cycles -> value unchanged; `clear_i`=1 together with 01 -> value 0 next cycle.
- Wrap (macro undefined): preload to 524287 by counting, then 01 -> value -524288 and `limit_o` pulses for 1 cycle; 10 -> back to 524287 and `limit_o` pulses for 1 cycle.
- Saturate (macro defined): at 524287, hold 01 for 3 cycles -> value stays 524287, `limit_o`=1 for 3 cycles; at -524288 with 10 -> value stays -524288, `limit_o`=1.
- STEP=4: 01 for 5 cycles -> 20; then 10 for 6 cycles -> -4.
